// File: rtl/ibex_rf_lockstep_checker.sv
// Lockstep checker for the rollback-capable FF register file: compares main vs. delayed shadow writes,
// issues fixed-length restore pulses, escalates to a sticky alarm. Optional RF_LOCKSTEP_STATS_EN adds mismatch_total_o.
module ibex_rf_lockstep_checker #(
    parameter int DataWidth     = 32,
    parameter int ShadowDelay   = 2,
    parameter int RestoreCycles = 2,
    parameter int MaxRetries    = 3,
    parameter int CleanCycles   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 main_we_i,
    input  logic [4:0]           main_waddr_i,
    input  logic [DataWidth-1:0] main_wdata_i,
    input  logic                 shdw_we_i,
    input  logic [4:0]           shdw_waddr_i,
    input  logic [DataWidth-1:0] shdw_wdata_i,
    input  logic                 rf_err_i,
    output logic                 comperator_mismatch_o,
    output logic                 alarm_o,
    output logic [3:0]           retry_cnt_o
`ifdef RF_LOCKSTEP_STATS_EN
    ,
    output logic [15:0]          mismatch_total_o
`endif
);

    typedef struct packed {
        logic                 we;
        logic [4:0]           waddr;
        logic [DataWidth-1:0] wdata;
    } wr_t;

    typedef enum logic [1:0] {
        ST_COMPARE = 2'd0,
        ST_RESTORE = 2'd1,
        ST_ALARM   = 2'd2
    } state_e;

    localparam int RcW = (RestoreCycles > 1) ? $clog2(RestoreCycles) : 1;
    localparam int CcW = $clog2(CleanCycles + 1);
    localparam logic [RcW-1:0] LastRestore = RcW'(RestoreCycles - 1);
    localparam logic [CcW-1:0] LastClean   = CcW'(CleanCycles - 1);
    localparam logic [4:0]     MaxRetriesW = 5'(MaxRetries);

    state_e                 state_q, state_d;
    wr_t                    dly_q [ShadowDelay];
    wr_t                    dly_d [ShadowDelay];
    logic [ShadowDelay-1:0] dly_vld_q, dly_vld_d;
    logic [3:0]             retry_q, retry_d;
    logic [CcW-1:0]         clean_q, clean_d;
    logic [RcW-1:0]         rst_cnt_q, rst_cnt_d;

    wr_t        tail;
    logic       cmp_en;
    logic       mismatch_det;
    logic [4:0] retry_inc;

    assign tail         = dly_q[ShadowDelay-1];
    assign cmp_en       = (state_q == ST_COMPARE) && dly_vld_q[ShadowDelay-1];
    // Two idle writes match regardless of address/data lines.
    assign mismatch_det = cmp_en &&
                          ((tail.we != shdw_we_i) ||
                           (tail.we && ((tail.waddr != shdw_waddr_i) || (tail.wdata != shdw_wdata_i))));
    assign retry_inc    = {1'b0, retry_q} + 5'd1;

    always_comb begin
        dly_d[0]     = {main_we_i, main_waddr_i, main_wdata_i};
        dly_vld_d    = '0;
        dly_vld_d[0] = 1'b1;
        for (int i = 1; i < ShadowDelay; i++) begin
            dly_d[i]     = dly_q[i-1];
            dly_vld_d[i] = dly_vld_q[i-1];
        end
        if (state_q == ST_RESTORE) begin
            dly_vld_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        clean_d   = clean_q;
        rst_cnt_d = rst_cnt_q;
        if (rf_err_i) begin
            state_d = ST_ALARM;
        end else begin
            case (state_q)
                ST_COMPARE: begin
                    if (mismatch_det) begin
                        if (retry_inc > MaxRetriesW) begin
                            state_d = ST_ALARM;
                        end else begin
                            state_d   = ST_RESTORE;
                            retry_d   = retry_inc[3:0];
                            clean_d   = '0;
                            rst_cnt_d = '0;
                        end
                    end else if (cmp_en) begin
                        if (clean_q == LastClean) begin
                            clean_d = '0;
                            retry_d = '0;
                        end else begin
                            clean_d = clean_q + 1'b1;
                        end
                    end
                end
                ST_RESTORE: begin
                    if (rst_cnt_q == LastRestore) begin
                        state_d = ST_COMPARE;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_ALARM;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_COMPARE;
            dly_vld_q <= '0;
            retry_q   <= '0;
            clean_q   <= '0;
            rst_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dly_vld_q <= dly_vld_d;
            retry_q   <= retry_d;
            clean_q   <= clean_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    // Payload needs no reset: it is never used while its valid bit is clear.
    always_ff @(posedge clk_i) begin
        dly_q <= dly_d;
    end

    assign comperator_mismatch_o = (state_q == ST_RESTORE);
    assign alarm_o               = (state_q == ST_ALARM);
    assign retry_cnt_o           = retry_q;

`ifdef RF_LOCKSTEP_STATS_EN
    logic [15:0] mm_total_q, mm_total_d;

    always_comb begin
        mm_total_d = mm_total_q;
        if (mismatch_det && !rf_err_i && (mm_total_q != 16'hFFFF)) begin
            mm_total_d = mm_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mm_total_q <= '0;
        end else begin
            mm_total_q <= mm_total_d;
        end
    end

    assign mismatch_total_o = mm_total_q;
`else
    // Statistics counter not built.
`endif

endmodule

// File: tb/tb_ibex_rf_lockstep_checker.sv
// Scoreboard bench: driver feeds random/directed write streams and pushes model predictions; monitor pops and compares each cycle.
module tb_ibex_rf_lockstep_checker;

    localparam int D    = 2;
    localparam int RC   = 2;
    localparam int MAXR = 3;
    localparam int CC   = 32;

    typedef struct packed {
        bit        we;
        bit [4:0]  a;
        bit [31:0] d;
    } wr_t;

    typedef struct packed {
        bit        mm;
        bit        al;
        bit [3:0]  rt;
        bit [15:0] tot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        main_we = 1'b0, shdw_we = 1'b0, rf_err = 1'b0;
    logic [4:0]  main_waddr = '0, shdw_waddr = '0;
    logic [31:0] main_wdata = '0, shdw_wdata = '0;
    logic        mm_o, al_o;
    logic [3:0]  rt_o;
    logic [15:0] tot_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t exp_q[$];
    wr_t  stim_hist[$];

    // Reference model state
    int   m_mode = 0;   // 0 compare, 1 restore, 2 alarm
    int   m_left = 0, m_retry = 0, m_clean = 0, m_tot = 0;
    wr_t  m_hist[$];

    always #5 clk = ~clk;

    ibex_rf_lockstep_checker #(
        .DataWidth(32), .ShadowDelay(D), .RestoreCycles(RC), .MaxRetries(MAXR), .CleanCycles(CC)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .main_we_i(main_we),
        .main_waddr_i(main_waddr),
        .main_wdata_i(main_wdata),
        .shdw_we_i(shdw_we),
        .shdw_waddr_i(shdw_waddr),
        .shdw_wdata_i(shdw_wdata),
        .rf_err_i(rf_err),
        .comperator_mismatch_o(mm_o),
        .alarm_o(al_o),
        .retry_cnt_o(rt_o)
`ifdef RF_LOCKSTEP_STATS_EN
        ,
        .mismatch_total_o(tot_o)
`endif
    );

`ifndef RF_LOCKSTEP_STATS_EN
    assign tot_o = '0;
`endif

    task automatic model_step(input bit r, input wr_t m, input wr_t s, input bit err);
        bit  have, mm;
        wr_t t;
        if (r) begin
            m_mode = 0; m_retry = 0; m_clean = 0; m_tot = 0; m_left = 0;
            m_hist.delete();
        end else if (err) begin
            m_mode = 2;
        end else if (m_mode == 0) begin
            have = (m_hist.size() >= D);
            mm   = 1'b0;
            if (have) begin
                t  = m_hist[m_hist.size() - D];
                mm = (t.we != s.we) || (t.we && ((t.a != s.a) || (t.d != s.d)));
            end
            m_hist.push_back(m);
            while (m_hist.size() > D) void'(m_hist.pop_front());
            if (mm) begin
                if (m_tot < 65535) m_tot++;
                if (m_retry + 1 > MAXR) begin
                    m_mode = 2;
                end else begin
                    m_retry++;
                    m_mode  = 1;
                    m_left  = RC;
                    m_clean = 0;
                    m_hist.delete();
                end
            end else if (have) begin
                m_clean++;
                if (m_clean == CC) begin
                    m_clean = 0;
                    m_retry = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_hist.delete();
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    function automatic wr_t rnd();
        wr_t w;
        w.we = 1'($urandom_range(0, 1));
        w.a  = 5'($urandom_range(0, 31));
        w.d  = $urandom;
        return w;
    endfunction

    function automatic wr_t replay();
        wr_t w;
        w = '0;
        if (stim_hist.size() >= D) w = stim_hist[stim_hist.size() - D];
        return w;
    endfunction

    task automatic tick(input bit r, input wr_t m, input wr_t s, input bit err);
        exp_t e;
        @(negedge clk);
        rst        = r;
        rf_err     = err;
        main_we    = m.we; main_waddr = m.a; main_wdata = m.d;
        shdw_we    = s.we; shdw_waddr = s.a; shdw_wdata = s.d;
        model_step(r, m, s, err);
        e.mm  = (m_mode == 1);
        e.al  = (m_mode == 2);
        e.rt  = 4'(m_retry);
        e.tot = 16'(m_tot);
        exp_q.push_back(e);
        stim_hist.push_back(m);
        while (stim_hist.size() > D) void'(stim_hist.pop_front());
    endtask

    task automatic run_ok(input int n);
        wr_t m;
        repeat (n) begin
            m = rnd();
            tick(1'b0, m, replay(), 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) tick(1'b1, rnd(), rnd(), 1'b0);
    endtask

    // Plants a main write, then corrupts the shadow copy when it replays D cycles later.
    task automatic inject(input int kind);
        wr_t m1, c;
        m1 = rnd();
        case (kind)
            0: begin m1 = '{we: 1'b1, a: 5'd5, d: 32'h1235}; c = m1; c.d = 32'h1234; end
            1: begin m1.we = 1'b1; m1.a = 5'd7; c = m1; c.we = 1'b0; end
            2: begin m1.we = 1'b0; m1.a = 5'd3; c = rnd(); c.we = 1'b0; c.a = 5'd9; end
            default: begin m1.we = 1'b1; c = m1; c.a = m1.a ^ 5'd1; end
        endcase
        tick(1'b0, m1, replay(), 1'b0);
        run_ok(D - 1);
        tick(1'b0, rnd(), c, 1'b0);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mismatch_o", int'(mm_o), int'(e.mm));
                check("alarm_o", int'(al_o), int'(e.al));
                check("retry_cnt_o", int'(rt_o), int'(e.rt));
`ifdef RF_LOCKSTEP_STATS_EN
                check("mismatch_total_o", int'(tot_o), int'(e.tot));
`endif
            end
        end
    end

    initial begin : driver
        int r;
        do_reset(3);
        run_ok(100);                        // identical streams
        inject(0);                          // data differs on x5
        run_ok(6);
        inject(1);                          // main writes x7, shadow idle
        run_ok(6);
        inject(2);                          // both idle, addresses differ
        run_ok(40);                         // clean interval clears retry count
        inject(0);
        run_ok(8);

        do_reset(1);
        run_ok(5);
        repeat (4) begin                    // escalation to alarm
            inject(1);
            run_ok(10 - (D + 1));
        end
        run_ok(10);
        tick(1'b0, rnd(), replay(), 1'b1);
        run_ok(3);

        do_reset(1);
        run_ok(5);
        inject(0);
        tick(1'b0, rnd(), replay(), 1'b1);  // rf_err during restore
        run_ok(3);
        do_reset(1);
        run_ok(5);
        inject(3);
        do_reset(1);                        // reset mid-restore
        run_ok(5);

        repeat (200) begin
            r = $urandom_range(0, 99);
            if (r < 8)                       inject($urandom_range(0, 3));
            else if (r < 10)                 tick(1'b0, rnd(), replay(), 1'b1);
            else if (m_mode == 2 && r < 40)  do_reset(1);
            else                             run_ok(1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
